// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_resp data-memory responder.
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } dmem_state_e;

  // Wait-state counter width; covers WAIT_CYC in 0..15
  localparam int unsigned CntW = 4;

  // Byte lanes within a 32-bit little-endian word
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Number of 32-bit words in a byte-addressed array of 2^addr_w bytes
  function automatic int unsigned words_of(input int unsigned addr_w);
    return 2 ** (addr_w - 2);
  endfunction

  // Word count for the default 10-bit byte address (1 KB)
  localparam int unsigned WORDS = words_of(10);

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte-lane merge for sb and sign-extending lane extract for lb.
// Purely combinational; the word-access paths pass the array word through unchanged.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [7:0]  wbyte,
  input  logic        byte_en,
  output logic [31:0] merged,
  output logic [31:0] rd_word
);

  logic [7:0] sel;

  // Replace the addressed lane for stores; pick and sign-extend it for loads
  always_comb begin
    merged  = word;
    sel     = word[7:0];
    unique case (lane)
      LANE0: begin
        merged[7:0] = wbyte;
        sel         = word[7:0];
      end
      LANE1: begin
        merged[15:8] = wbyte;
        sel          = word[15:8];
      end
      LANE2: begin
        merged[23:16] = wbyte;
        sel           = word[23:16];
      end
      LANE3: begin
        merged[31:24] = wbyte;
        sel           = word[31:24];
      end
      default: begin
        merged = word;
        sel    = word[7:0];
      end
    endcase
    rd_word = byte_en ? {{24{sel[7]}}, sel} : word;
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: responder side of the CPU data-memory port.
// 256 x 32 little-endian array behind a valid/ready request, WAIT_CYC wait states,
// one access cycle and a held response. Optional misalignment error reporting is
// enabled by defining DMEM_ERR_EN; without it rsp_err is 0 and word accesses align down.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned      Words    = words_of(ADDR_W);
  localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_CYC);

  dmem_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Latched request
  logic              we_q;
  logic              byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Response registers
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem_q [Words];

  logic              accept;
  logic              err_flag;
  logic [ADDR_W-3:0] idx;
  logic [31:0]       mem_word;
  logic [31:0]       merged;
  logic [31:0]       rd_word;
  logic [31:0]       wr_word;

  assign accept   = req_valid && req_ready;
  assign idx      = addr_q[ADDR_W-1:2];
  assign mem_word = mem_q[idx];

`ifdef DMEM_ERR_EN
  // Only word accesses can be misaligned; byte accesses use addr[1:0] as the lane
  assign err_flag = !byte_q && (addr_q[1:0] != 2'b00);
`else
  assign err_flag = 1'b0;
`endif

  dmem_lane u_lane (
    .word    (mem_word),
    .lane    (addr_q[1:0]),
    .wbyte   (wdata_q[7:0]),
    .byte_en (byte_q),
    .merged  (merged),
    .rd_word (rd_word)
  );

  assign wr_word = byte_q ? merged : wdata_q;

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d   = WaitInit;
          state_d = (WAIT_CYC == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        // <= guards against a stuck counter if it ever reads 0 here
        if (cnt_q <= CntW'(1)) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  // Capture the request on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      byte_q  <= req_byte;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response data and error, loaded in ACCESS and held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == StAccess) begin
      rdata_q <= (we_q || err_flag) ? 32'h0 : rd_word;
      err_q   <= err_flag;
    end
  end

  // Array write; contents have no reset and a coinciding rst blocks the write
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StAccess) && we_q && !err_flag) begin
      mem_q[idx] <= wr_word;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp. Expected responses are queued when a
// request is accepted and popped at the response handshake. Misalignment-error checks
// are compiled in when DMEM_ERR_EN is defined.
module tb_dmem_resp;

  parameter int unsigned WaitCyc = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_resp #(
    .ADDR_W   (10),
    .WAIT_CYC (WaitCyc)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  // Drive a request from a negedge, queue its expected response and measure latency
  task automatic issue(input logic we, input logic bt, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    int n;
    exp_t e;
    req_we    = we;
    req_byte  = bt;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    e.rdata = er;
    e.err   = ee;
    sb_q.push_back(e);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      check_eq("busy_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(n), 32'(WaitCyc + 2));
  endtask

  // Hold off the response, then complete the handshake against the scoreboard
  task automatic complete(input int hold);
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      if (sb_q.size() > 0) check_eq("hold_rsp_rdata", rsp_rdata, sb_q[0].rdata);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_rdata", rsp_rdata, e.rdata);
      check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Accept a store, then assert rst after 'delay' further cycles
  task automatic store_then_reset(input logic [9:0] addr, input logic [31:0] wdata,
                                  input int delay, input string tag);
    req_we    = 1'b1;
    req_byte  = 1'b0;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check_eq({tag, "_accept_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (delay) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Word store/load
    issue(1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    complete(0);
    issue(1'b0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    complete(0);

    // Byte store merges one lane
    issue(1'b1, 1'b0, 10'h020, 32'h11223344, 32'h0, 1'b0);
    complete(0);
    issue(1'b1, 1'b1, 10'h022, 32'h555555AA, 32'h0, 1'b0);
    complete(0);
    issue(1'b0, 1'b0, 10'h020, 32'h0, 32'h11AA3344, 1'b0);
    complete(0);

    // Byte loads, sign extension on every lane
    issue(1'b0, 1'b1, 10'h022, 32'h0, 32'hFFFFFFAA, 1'b0);
    complete(0);
    issue(1'b0, 1'b1, 10'h021, 32'h0, 32'h00000033, 1'b0);
    complete(0);
    issue(1'b0, 1'b1, 10'h020, 32'h0, 32'h00000044, 1'b0);
    complete(0);
    issue(1'b0, 1'b1, 10'h023, 32'h0, 32'h00000011, 1'b0);
    complete(0);

    // Backpressure with a new request pending during RESP
    issue(1'b0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 10'h020;
    req_wdata = 32'h0;
    req_valid = 1'b1;
    complete(5);
    issue(1'b0, 1'b0, 10'h020, 32'h0, 32'h11AA3344, 1'b0);
    complete(0);

    // Reset during WAIT drops the store; reset with ACCESS suppresses the write
    issue(1'b1, 1'b0, 10'h030, 32'hCAFEF00D, 32'h0, 1'b0);
    complete(0);
    store_then_reset(10'h030, 32'h12345678, 0, "rst_wait");
    issue(1'b0, 1'b0, 10'h030, 32'h0, 32'hCAFEF00D, 1'b0);
    complete(0);
    store_then_reset(10'h030, 32'h12345678, WaitCyc, "rst_access");
    issue(1'b0, 1'b0, 10'h030, 32'h0, 32'hCAFEF00D, 1'b0);
    complete(0);

`ifdef DMEM_ERR_EN
    // Misaligned word accesses flag an error, return 0 and leave the array alone
    issue(1'b1, 1'b0, 10'h004, 32'h0BADCAFE, 32'h0, 1'b0);
    complete(0);
    issue(1'b0, 1'b0, 10'h005, 32'h0, 32'h0, 1'b1);
    complete(0);
    issue(1'b1, 1'b0, 10'h006, 32'hFFFFFFFF, 32'h0, 1'b1);
    complete(0);
    issue(1'b0, 1'b0, 10'h004, 32'h0, 32'h0BADCAFE, 1'b0);
    complete(0);
`else
    // Misaligned word accesses align down silently
    issue(1'b0, 1'b0, 10'h012, 32'h0, 32'hDEADBEEF, 1'b0);
    complete(0);
    issue(1'b1, 1'b0, 10'h017, 32'hA5A55A5A, 32'h0, 1'b0);
    complete(0);
    issue(1'b0, 1'b0, 10'h014, 32'h0, 32'hA5A55A5A, 1'b0);
    complete(0);
`endif

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
